// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access size codes,
// FSM state encodings, bus widths and the access legality rule.
package mem_stage_lsu_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  // funct3 access size / sign codes
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // An access is legal when its funct3 exists for its direction and the
  // address is naturally aligned to the access size.
  function automatic logic lsu_legal(input logic [2:0] funct3,
                                     input logic [1:0] off,
                                     input logic       is_store);
    logic ok;
    case (funct3)
      LSU_B:   ok = 1'b1;
      LSU_H:   ok = ~off[0];
      LSU_W:   ok = (off == 2'b00);
      LSU_BU:  ok = ~is_store;
      LSU_HU:  ok = ~is_store & ~off[0];
      default: ok = 1'b0;
    endcase
    lsu_legal = ok;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Selects the addressed byte/half of a read word and sign/zero extends it.
module mem_stage_lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  lanes [BE_W];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    assign lanes[gi] = rdata[8*gi +: 8];
  end

  // Pick the lane(s) and apply the extension the funct3 asks for.
  always_comb begin
    byte_sel = lanes[off];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LSU_B:   data = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  data = {24'h0, byte_sel};
      LSU_H:   data = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one req/ack bus cycle per legal access,
// stalls the pipeline while it is outstanding and formats load data.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] mem_alu_result_i,
  input  logic [XLEN-1:0] mem_wdata_i,
  input  logic            mem_mem_read_i,
  input  logic            mem_mem_write_i,
  input  logic [2:0]      mem_funct3_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [BE_W-1:0] dmem_be_o,
  input  logic            dmem_ack_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic [XLEN-1:0] mem_rdata_o,
  output logic            lsu_stall_o,
  output logic            lsu_misalign_o,
  output logic            lsu_bus_err_o
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]      state_reg;
  logic [15:0]     cnt_reg;
  logic [XLEN-1:0] addr_reg, wdata_reg, rdata_reg;
  logic [BE_W-1:0] be_reg;
  logic            we_reg, bus_err_reg;
  logic [2:0]      f3_reg;
  logic [1:0]      off_reg;

  logic            access, is_store, legal, start;
  logic [1:0]      off;
  logic [BE_W-1:0] be_next;
  logic [XLEN-1:0] wdata_next, load_fmt;

  // Read+write together is treated as a load.
  assign access   = mem_mem_read_i | mem_mem_write_i;
  assign is_store = mem_mem_write_i & ~mem_mem_read_i;
  assign off      = mem_alu_result_i[1:0];
  assign legal    = lsu_legal(mem_funct3_i, off, is_store);
  assign start    = (state_reg == ST_IDLE) & access & legal;

  // Store lane replication and byte enables; loads read the whole word.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = mem_wdata_i;
    if (is_store) begin
      case (mem_funct3_i)
        LSU_B: begin
          be_next    = 4'b0001 << off;
          wdata_next = {4{mem_wdata_i[7:0]}};
        end
        LSU_H: begin
          be_next    = 4'b0011 << {off[1], 1'b0};
          wdata_next = {2{mem_wdata_i[15:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = mem_wdata_i;
        end
      endcase
    end
  end

  mem_stage_lsu_load_align u_align (
    .rdata  (dmem_rdata_i),
    .off    (off_reg),
    .funct3 (f3_reg),
    .data   (load_fmt)
  );

  // IDLE -> BUSY on a legal access, BUSY -> DONE on ack or timeout, DONE -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      be_reg      <= '0;
      we_reg      <= 1'b0;
      bus_err_reg <= 1'b0;
      f3_reg      <= '0;
      off_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          bus_err_reg <= 1'b0;
          if (start) begin
            addr_reg  <= {mem_alu_result_i[XLEN-1:2], 2'b00};
            wdata_reg <= wdata_next;
            be_reg    <= be_next;
            we_reg    <= is_store;
            f3_reg    <= mem_funct3_i;
            off_reg   <= off;
            cnt_reg   <= '0;
            state_reg <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dmem_ack_i) begin
            // Ack beats a simultaneous timeout.
            if (!we_reg) rdata_reg <= load_fmt;
            state_reg <= ST_DONE;
          end else if (cnt_reg == CNT_LAST) begin
            rdata_reg   <= '0;
            bus_err_reg <= 1'b1;
            state_reg   <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        default: begin
          // DONE: MEM/WB captures the result at this edge; the access still
          // visible on EX/MEM is not reissued.
          bus_err_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  assign dmem_req_o     = (state_reg == ST_BUSY);
  assign dmem_we_o      = we_reg;
  assign dmem_addr_o    = addr_reg;
  assign dmem_wdata_o   = wdata_reg;
  assign dmem_be_o      = be_reg;
  assign mem_rdata_o    = rdata_reg;
  assign lsu_bus_err_o  = bus_err_reg;
  assign lsu_stall_o    = start | (state_reg == ST_BUSY);
  assign lsu_misalign_o = (state_reg == ST_IDLE) & access & ~legal;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed and randomized checks of mem_stage_lsu against a behavioural model.
module tb_mem_stage_lsu;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu, wd, rdata_bus;
  logic        rd, wr, ack;
  logic [2:0]  f3;
  logic        req, we, stall, misalign, bus_err;
  logic [31:0] addr_o, wdata_o, mem_rdata;
  logic [3:0]  be;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_alu_result_i (alu),
    .mem_wdata_i      (wd),
    .mem_mem_read_i   (rd),
    .mem_mem_write_i  (wr),
    .mem_funct3_i     (f3),
    .dmem_req_o       (req),
    .dmem_we_o        (we),
    .dmem_addr_o      (addr_o),
    .dmem_wdata_o     (wdata_o),
    .dmem_be_o        (be),
    .dmem_ack_i       (ack),
    .dmem_rdata_i     (rdata_bus),
    .mem_rdata_o      (mem_rdata),
    .lsu_stall_o      (stall),
    .lsu_misalign_o   (misalign),
    .lsu_bus_err_o    (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Legality from access size and natural alignment.
  function automatic bit m_legal(input bit st, input logic [2:0] fc, input logic [31:0] a);
    int size;
    case (fc)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    return 1'b0;
    endcase
    if (st && fc[2]) return 1'b0;
    return (int'(a[1:0]) % size) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] fc, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    int sh;
    case (fc)
      3'd0, 3'd4: begin
        sh = 8 * int'(a[1:0]);
        v = (w >> sh) & 32'hFF;
        if (fc == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        sh = 16 * int'(a[1]);
        v = (w >> sh) & 32'hFFFF;
        if (fc == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_be(input bit st, input logic [2:0] fc, input logic [31:0] a);
    if (!st || fc == 3'd2) return 4'b1111;
    if (fc == 3'd0) return 4'(1 << int'(a[1:0]));
    return 4'(3 << (int'(a[1:0]) & 2));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] fc, input logic [31:0] w);
    if (fc == 3'd0) return (w & 32'hFF) * 32'h0101_0101;
    if (fc == 3'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  // One MEM-stage access; waits = wait cycles before ack, negative = never ack.
  task automatic run_access(input bit r, input bit w, input logic [2:0] fc,
                            input logic [31:0] a, input logic [31:0] wdat,
                            input logic [31:0] rword, input int waits);
    bit st, lg, acked, tout;
    int busy, stall_cnt;
    st = w && !r;
    lg = m_legal(st, fc, a);
    @(negedge clk);
    rd = r; wr = w; f3 = fc; alu = a; wd = wdat; ack = 1'b0;
    #1;
    chk("idle_misalign", 32'(misalign), 32'(!lg));
    chk("idle_req", 32'(req), 32'h0);
    chk("idle_stall", 32'(stall), 32'(lg));
    if (!lg) begin
      @(negedge clk);
      chk("mis_req_next", 32'(req), 32'h0);
      chk("mis_rdata_held", mem_rdata, model_rdata);
      rd = 1'b0; wr = 1'b0;
      $display("txn rd=%0d wr=%0d f3=%0d addr=%h misaligned", r, w, fc, a);
      return;
    end
    stall_cnt = 1;
    acked = 1'b0;
    busy = 0;
    while (!acked && busy < T) begin
      @(negedge clk);
      busy++;
      chk("busy_req", 32'(req), 32'h1);
      chk("busy_stall", 32'(stall), 32'h1);
      chk("busy_addr", addr_o, {a[31:2], 2'b00});
      chk("busy_we", 32'(we), 32'(st));
      chk("busy_be", 32'(be), 32'(m_be(st, fc, a)));
      if (st) chk("busy_wdata", wdata_o, m_wdata(fc, wdat));
      stall_cnt += int'(stall);
      acked = (waits >= 0) && (busy == waits + 1);
      ack = acked;
      rdata_bus = acked ? rword : $urandom;
    end
    tout = !acked;
    if (tout) model_rdata = 32'h0;
    else if (!st) model_rdata = m_load(fc, a, rword);
    @(negedge clk);
    ack = 1'b0;
    rdata_bus = $urandom;
    #1;
    chk("done_stall", 32'(stall), 32'h0);
    chk("done_req", 32'(req), 32'h0);
    chk("done_bus_err", 32'(bus_err), 32'(tout));
    chk("done_rdata", mem_rdata, model_rdata);
    chk("stall_cycles", 32'(stall_cnt), tout ? 32'(T + 1) : 32'(waits + 2));
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    #1;
    chk("after_bus_err", 32'(bus_err), 32'h0);
    chk("after_stall", 32'(stall), 32'h0);
    chk("after_rdata", mem_rdata, model_rdata);
    $display("txn rd=%0d wr=%0d f3=%0d addr=%h waits=%0d timeout=%0d rdata=%h",
             r, w, fc, a, waits, tout, mem_rdata);
  endtask

  initial begin
    logic [2:0] f3_tab [6];
    int idx, wt;
    bit r, w;
    f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd2;
    f3_tab[3] = 3'd4; f3_tab[4] = 3'd5; f3_tab[5] = 3'd3;
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; f3 = 3'd0; alu = '0; wd = '0;
    ack = 1'b0; rdata_bus = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    chk("rst_be", 32'(be), 32'h0);
    rst_n = 1'b1;

    // Directed cases
    run_access(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    run_access(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 0);
    run_access(1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 1);
    run_access(1, 0, 3'd1, 32'h102, 32'h0, 32'h80FF_0000, 0);
    run_access(0, 1, 3'd0, 32'h201, 32'h0000_00A5, 32'h0, 3);
    run_access(0, 1, 3'd1, 32'h202, 32'h1234_BEEF, 32'h0, 0);
    run_access(1, 0, 3'd2, 32'h102, 32'h0, 32'h0, 0);
    run_access(0, 1, 3'd1, 32'h301, 32'h0, 32'h0, 0);
    run_access(0, 1, 3'd4, 32'h300, 32'h0, 32'h0, 0);
    run_access(1, 1, 3'd5, 32'h102, 32'h0, 32'hABCD_1234, 0);
    run_access(1, 0, 3'd2, 32'h400, 32'h0, 32'h1111_2222, -1);
    run_access(1, 0, 3'd2, 32'h404, 32'h0, 32'h3333_4444, T - 1);

    // Reset in the middle of a bus access
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; f3 = 3'd2; alu = 32'h500;
    @(negedge clk);
    chk("pre_rst_req", 32'(req), 32'h1);
    rst_n = 1'b0; rd = 1'b0;
    #1;
    chk("mid_rst_req", 32'(req), 32'h0);
    chk("mid_rst_stall", 32'(stall), 32'h0);
    model_rdata = 32'h0;
    chk("mid_rst_rdata", mem_rdata, model_rdata);
    @(negedge clk);
    rst_n = 1'b1;
    run_access(1, 0, 3'd2, 32'h504, 32'h0, 32'hCAFE_F00D, 0);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      idx = int'($urandom_range(0, 5));
      r = 1'($urandom_range(0, 1));
      w = r ? 1'($urandom_range(0, 1)) : 1'b1;
      wt = int'($urandom_range(0, 5));
      if (wt == 5) wt = -1;
      run_access(r, w, f3_tab[idx], $urandom, $urandom, $urandom, wt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
